// File: rtl/pwm_demod.sv
// pwm_demod: recovers the 7-bit sample carried by each PWM frame.
// A frame starts with a rising edge, and its high time is sample+1 clocks.
// The block also reports the sawtooth wrap period, silence and framing errors.
// Optional build macro PWM_DEMOD_SYNC_EN: when it is defined, pwm_in passes
// through a two-flop synchronizer first. This adds 2 clocks of latency.
module pwm_demod #(
  parameter int FRAME_CYCLES   = 129,
  parameter int WRAP_DROP      = 64,
  parameter int SILENCE_FRAMES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pwm_in,
  output logic [6:0]  sample,
  output logic        sample_valid,
  output logic        locked,
  output logic [15:0] wrap_period,
  output logic        wrap_valid,
  output logic        silent,
  output logic        frame_err
);

  typedef enum logic [1:0] {HUNT = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [8:0] LEN_OK    = 9'(FRAME_CYCLES);
  localparam logic [8:0] LEN_TMO   = 9'(2 * FRAME_CYCLES);
  localparam logic [7:0] DROP_MIN  = 8'(WRAP_DROP);
  localparam logic [4:0] SILENT_TH = 5'(SILENCE_FRAMES - 1);

  state_t      state_q, state_d;
  logic        pwm_s, pwm_q, rise;
  logic [8:0]  len_cnt_q;
  logic [7:0]  hi_cnt_q;
  logic        len_ok, timeout;
  logic        emit, err, track, leave;
  logic [6:0]  new_sample;
  logic [7:0]  drop;
  logic        wrap_det;

  logic [6:0]  sample_q, sample_d;
  logic [15:0] frm_cnt_q, frm_cnt_d;
  logic [15:0] wrap_period_q, wrap_period_d;
  logic        wrap_valid_q, wrap_valid_d;
  logic        armed_q, armed_d;
  logic [4:0]  same_cnt_q, same_cnt_d;
  logic        silent_q, silent_d;
  logic        sample_valid_q, frame_err_q, locked_q;

`ifdef PWM_DEMOD_SYNC_EN
  logic [1:0] sync_q;
  // Two-flop synchronizer for an external input. Its reset value is high so
  // that a reset in the middle of a high phase does not create a false edge.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], pwm_in};
  end
  assign pwm_s = sync_q[1];
`else
  assign pwm_s = pwm_in;
`endif

  // Previous-input register for edge detection. It resets high, so the
  // first rise after reset is always a genuine low-to-high transition.
  always_ff @(posedge clk) begin
    if (rst) pwm_q <= 1'b1;
    else     pwm_q <= pwm_s;
  end
  assign rise = pwm_s & ~pwm_q;

  // Frame counters restart on every rise. The rise cycle counts as cycle 1
  // of the new frame, and it also counts as a high cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_cnt_q <= '0;
      hi_cnt_q  <= '0;
    end else if (rise) begin
      len_cnt_q <= 9'd1;
      hi_cnt_q  <= 8'd1;
    end else begin
      if (len_cnt_q != 9'd511)           len_cnt_q <= len_cnt_q + 9'd1;
      if (pwm_s && hi_cnt_q != 8'd255)   hi_cnt_q  <= hi_cnt_q + 8'd1;
    end
  end

  assign len_ok  = (len_cnt_q == LEN_OK);
  assign timeout = ~rise & (len_cnt_q == LEN_TMO);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= HUNT;
    else     state_q <= state_d;
  end

  // FSM next state. A rise in the same cycle as a timeout takes priority.
  always_comb begin
    state_d = state_q;
    if (rise) begin
      case (state_q)
        HUNT:    state_d = ACQUIRE;
        ACQUIRE: if (len_ok)  state_d = LOCKED;
        LOCKED:  if (!len_ok) state_d = ACQUIRE;
        default: state_d = HUNT;
      endcase
    end else if (timeout) begin
      state_d = HUNT;
    end
  end

  // FSM outputs: sample emission, error pulse, and the LOCKED bookkeeping.
  always_comb begin
    emit  = rise & len_ok & (state_q != HUNT);
    err   = (state_q != HUNT) & ((rise & ~len_ok) | timeout);
    track = emit & (state_q == LOCKED);
    leave = (state_q == LOCKED) & (state_d != LOCKED);
  end

  // Decoded sample, and the wrap test against the previous sample.
  always_comb begin
    if (hi_cnt_q >= 8'd129) new_sample = 7'd127;
    else                    new_sample = 7'(hi_cnt_q - 8'd1);
    drop     = {1'b0, sample_q} - {1'b0, new_sample};
    wrap_det = (sample_q > new_sample) && (drop >= DROP_MIN);
  end

  // Next-state logic for wrap tracking and silence, which advance only on
  // samples taken while already locked. Leaving LOCKED clears this state.
  always_comb begin
    sample_d      = sample_q;
    frm_cnt_d     = frm_cnt_q;
    armed_d       = armed_q;
    same_cnt_d    = same_cnt_q;
    silent_d      = silent_q;
    wrap_period_d = wrap_period_q;
    wrap_valid_d  = 1'b0;
    if (emit) sample_d = new_sample;
    if (track) begin
      if (wrap_det) begin
        frm_cnt_d = 16'd1;
        if (armed_q) begin
          wrap_period_d = frm_cnt_q;
          wrap_valid_d  = 1'b1;
        end
        armed_d = 1'b1;
      end else if (frm_cnt_q != 16'hFFFF) begin
        frm_cnt_d = frm_cnt_q + 16'd1;
      end
      if (new_sample == sample_q) begin
        if (same_cnt_q != 5'd31) same_cnt_d = same_cnt_q + 5'd1;
        silent_d = (same_cnt_q >= SILENT_TH);
      end else begin
        same_cnt_d = '0;
        silent_d   = 1'b0;
      end
    end
    if (leave) begin
      armed_d    = 1'b0;
      frm_cnt_d  = '0;
      same_cnt_d = '0;
      silent_d   = 1'b0;
    end
  end

  // Output and tracking registers. All pulses are registered one clock after the rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      frame_err_q    <= 1'b0;
      locked_q       <= 1'b0;
      frm_cnt_q      <= '0;
      armed_q        <= 1'b0;
      same_cnt_q     <= '0;
      silent_q       <= 1'b0;
      wrap_period_q  <= '0;
      wrap_valid_q   <= 1'b0;
    end else begin
      sample_q       <= sample_d;
      sample_valid_q <= emit;
      frame_err_q    <= err;
      locked_q       <= (state_d == LOCKED);
      frm_cnt_q      <= frm_cnt_d;
      armed_q        <= armed_d;
      same_cnt_q     <= same_cnt_d;
      silent_q       <= silent_d;
      wrap_period_q  <= wrap_period_d;
      wrap_valid_q   <= wrap_valid_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign frame_err    = frame_err_q;
  assign locked       = locked_q;
  assign wrap_period  = wrap_period_q;
  assign wrap_valid   = wrap_valid_q;
  assign silent       = silent_q;

endmodule

// File: tb/tb_pwm_demod.sv
// Scoreboard bench for pwm_demod. The stimulus thread queues the event expected
// at the end of each frame. A monitor pops an entry on every output pulse.
`timescale 1ns/1ps
module tb_pwm_demod;

  logic        clk = 1'b0;
  logic        rst;
  logic        pwm_in;
  logic [6:0]  sample;
  logic        sample_valid;
  logic        locked;
  logic [15:0] wrap_period;
  logic        wrap_valid;
  logic        silent;
  logic        frame_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string name;
    int    kind;   // 1 = sample event, 2 = frame error event
    int    smp;
    bit    sil;
    bit    wv;
    int    wp;
  } exp_t;

  exp_t exp_q[$];

  pwm_demod dut (
    .clk          (clk),
    .rst          (rst),
    .pwm_in       (pwm_in),
    .sample       (sample),
    .sample_valid (sample_valid),
    .locked       (locked),
    .wrap_period  (wrap_period),
    .wrap_valid   (wrap_valid),
    .silent       (silent),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  // Drive one frame: high for hi clocks, then low for the rest of len clocks.
  task automatic drive_frame(input int hi, input int len);
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      pwm_in = (c < hi);
    end
  endtask

  task automatic exp_smp(input string nm, input int s, input bit sil, input bit wv, input int wp);
    exp_t e;
    e.name = nm; e.kind = 1; e.smp = s; e.sil = sil; e.wv = wv; e.wp = wp;
    exp_q.push_back(e);
  endtask

  task automatic exp_err(input string nm);
    exp_t e;
    e.name = nm; e.kind = 2; e.smp = 0; e.sil = 0; e.wv = 0; e.wp = 0;
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string nm);
    checks++;
    if (sample !== 7'd0 || sample_valid !== 1'b0 || locked !== 1'b0 || wrap_period !== 16'd0 ||
        wrap_valid !== 1'b0 || silent !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL %s got smp=%0d sv=%0d lck=%0d wp=%0d wv=%0d sil=%0d fe=%0d required all 0",
               nm, sample, sample_valid, locked, wrap_period, wrap_valid, silent, frame_err);
    end else begin
      $display("chk %s outputs all 0", nm);
    end
  endtask

  // Monitor: compares each output pulse against the oldest queued expectation.
  initial begin
    exp_t e;
    bit   ok;
    forever begin
      @(posedge clk);
      #2;
      if (sample_valid === 1'b1 || frame_err === 1'b1 || wrap_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event got sv=%0d fe=%0d wv=%0d smp=%0d required no event",
                   sample_valid, frame_err, wrap_valid, sample);
        end else begin
          e = exp_q.pop_front();
          if (e.kind == 1) begin
            ok = (sample_valid === 1'b1) && (frame_err === 1'b0) && (sample === 7'(e.smp)) &&
                 (locked === 1'b1) && (silent === e.sil) && (wrap_valid === e.wv) &&
                 (!e.wv || wrap_period === 16'(e.wp));
            if (!ok) begin
              errors++;
              $display("FAIL %s got sv=%0d fe=%0d smp=%0d lck=%0d sil=%0d wv=%0d wp=%0d required sv=1 fe=0 smp=%0d lck=1 sil=%0d wv=%0d wp=%0d",
                       e.name, sample_valid, frame_err, sample, locked, silent, wrap_valid,
                       wrap_period, e.smp, e.sil, e.wv, e.wp);
            end else begin
              $display("evt %s smp=%0d lck=%0d sil=%0d wv=%0d wp=%0d",
                       e.name, sample, locked, silent, wrap_valid, wrap_period);
            end
          end else begin
            ok = (frame_err === 1'b1) && (sample_valid === 1'b0) && (locked === 1'b0) &&
                 (wrap_valid === 1'b0);
            if (!ok) begin
              errors++;
              $display("FAIL %s got fe=%0d sv=%0d lck=%0d wv=%0d required fe=1 sv=0 lck=0 wv=0",
                       e.name, frame_err, sample_valid, locked, wrap_valid);
            end else begin
              $display("evt %s frame_err lck=%0d", e.name, locked);
            end
          end
        end
      end
    end
  end

  // Watchdog so that the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // Stimulus: directed frames, with each expectation queued before its frame.
  initial begin
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Lock onto a mid-scale stream, then test the extreme samples and wraps.
    exp_smp("lock64",   64,  0, 0, 0); drive_frame(65, 129);
    exp_smp("hold64a",  64,  0, 0, 0); drive_frame(65, 129);
    exp_smp("hold64b",  64,  0, 0, 0); drive_frame(65, 129);
    exp_smp("min0_arm", 0,   0, 0, 0); drive_frame(1, 129);   // drop 64: arms only
    exp_smp("max127",   127, 0, 0, 0); drive_frame(128, 129);
    exp_smp("wrap_p2",  0,   0, 1, 2); drive_frame(1, 129);   // drop 127: period 2
    exp_smp("mid63",    63,  0, 0, 0); drive_frame(64, 129);
    exp_smp("drop63",   0,   0, 0, 0); drive_frame(1, 129);   // drop 63: no wrap

    // A short frame breaks the lock, and the next good frame relocks.
    exp_err("short120");                drive_frame(10, 120);
    exp_smp("relock40", 40, 0, 0, 0);  drive_frame(41, 129);

    // Silence: silent rises on the 16th repeat of the sample.
    for (int k = 1; k <= 19; k++) begin
      exp_smp($sformatf("rep40_%0d", k), 40, (k >= 16), 0, 0);
      drive_frame(41, 129);
    end
    exp_smp("change41", 41, 0, 0, 0); drive_frame(42, 129);

    // Sawtooth in steps of 4 (32 frames per wrap). The first wrap arms and the second reports 32.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 32; i++) begin
        exp_smp($sformatf("ramp%0d_%0d", r, 4 * i), 4 * i, 0, 0, 0);
        drive_frame(4 * i + 1, 129);
      end
    end
    exp_smp("wrap_p32", 0, 0, 1, 32); drive_frame(1, 129);

    // Timeout while locked: one error, then silence in HUNT.
    exp_err("timeout");
    drive_frame(1, 600);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL hunt_unlocked got lck=%0d required 0", locked);
    end else begin
      $display("chk hunt_unlocked lck=0");
    end

    // Relock from HUNT. 100 -> 20 is the first wrap after locking, so it only arms.
    exp_smp("hunt_relock100", 100, 0, 0, 0); drive_frame(101, 129);
    exp_smp("s20",            20,  0, 0, 0); drive_frame(21, 129);

    // Reset pulse in the middle of a high phase.
    for (int c = 0; c < 129; c++) begin
      @(negedge clk);
      pwm_in = (c < 50);
      if (c == 30) rst = 1'b1;
      if (c == 31) begin
        check_zero("mid_frame_rst");
        rst = 1'b0;
      end
    end
    exp_smp("post_rst_lock30", 30, 0, 0, 0); drive_frame(31, 129);
    exp_smp("post_rst_30",     30, 0, 0, 0); drive_frame(31, 129);
    drive_frame(1, 20);   // this rise ends the previous frame
    repeat (10) @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending events required 0", exp_q.size());
    end else begin
      $display("chk drain all expected events seen");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
